// File: rtl/opb_status_bank.sv
// OPB slave exposing C_NUM_CH user status words, each with a live/snapshot value,
// a sticky OR-accumulated copy and a saturating transition counter on one watched bit.
module opb_status_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010803FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter int          C_SNAPSHOT   = 1,
  parameter int          C_CNT_BIT    = 0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [32*C_NUM_CH-1:0]    user_data_in
);

  localparam logic [29:0] L_CTRL_OFF = 30'(4 * C_NUM_CH);

  logic [31:0]         w_addr;
  logic [31:0]         w_rel;
  logic [29:0]         w_off;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata;
  logic                w_hit;
  logic                w_ack_d;
  logic                w_wr;
  logic                w_ctrl_wr;
  logic                w_snap_all;
  logic                w_clr_all;
  logic                w_unused;
  logic [31:0]         w_user       [C_NUM_CH];
  logic [31:0]         w_sticky_clr [C_NUM_CH];
  logic [C_NUM_CH-1:0] w_cnt_clr;
  logic [C_NUM_CH-1:0] w_edge;

  logic                r_ack;
  logic [31:0]         r_dbus;
  logic [31:0]         r_snap   [C_NUM_CH];
  logic [31:0]         r_sticky [C_NUM_CH];
  logic [31:0]         r_cnt    [C_NUM_CH];
  logic [C_NUM_CH-1:0] r_prev;

  assign w_addr     = OPB_ABus;
  assign w_wdata    = OPB_DBus;
  assign w_rel      = w_addr - C_BASEADDR;
  assign w_off      = w_rel[31:2];
  assign w_hit      = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  // Masking with r_ack forces a dead cycle between acks while select is held.
  assign w_ack_d    = w_hit && !r_ack;
  assign w_wr       = w_ack_d && !OPB_RNW;
  assign w_ctrl_wr  = w_wr && (w_off == L_CTRL_OFF);
  assign w_snap_all = w_ctrl_wr && OPB_DBus[C_OPB_DWIDTH-1];
  assign w_clr_all  = w_ctrl_wr && OPB_DBus[C_OPB_DWIDTH-2];
  assign w_unused   = &{1'b0, OPB_BE, OPB_seqAddr, w_rel[1:0]};

  assign Sl_xferAck = r_ack;
  assign Sl_DBus    = r_dbus;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  for (genvar g = 0; g < C_NUM_CH; g++) begin : g_user
    assign w_user[g] = user_data_in[32*g +: 32];
  end

  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < C_NUM_CH; n++) begin
      w_edge[n]       = r_prev[n] != w_user[n][C_CNT_BIT];
      w_sticky_clr[n] = w_clr_all ? '1 : '0;
      w_cnt_clr[n]    = w_clr_all;
      if (w_wr && (w_off == 30'(4*n + 1))) w_sticky_clr[n] = w_wdata;
      if (w_wr && (w_off == 30'(4*n + 2))) w_cnt_clr[n]    = 1'b1;
      if (w_off == 30'(4*n))     w_rdata = (C_SNAPSHOT != 0) ? r_snap[n] : w_user[n];
      if (w_off == 30'(4*n + 1)) w_rdata = r_sticky[n];
      if (w_off == 30'(4*n + 2)) w_rdata = r_cnt[n];
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_ack  <= 1'b0;
      r_dbus <= '0;
    end else begin
      r_ack  <= w_ack_d;
      r_dbus <= (w_ack_d && OPB_RNW) ? w_rdata : '0;
    end
  end

  // NOTE: the per-channel arrays are flops, not RAM, so they take the async reset like any other state.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_prev <= '0;
      for (int n = 0; n < C_NUM_CH; n++) begin
        r_snap[n]   <= '0;
        r_sticky[n] <= '0;
        r_cnt[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < C_NUM_CH; n++) begin
        r_prev[n]   <= w_user[n][C_CNT_BIT];
        r_sticky[n] <= (r_sticky[n] & ~w_sticky_clr[n]) | w_user[n];
        if (w_snap_all) r_snap[n] <= w_user[n];
        if (w_cnt_clr[n]) begin
          r_cnt[n] <= w_edge[n] ? 32'd1 : 32'd0;
        end else if (w_edge[n] && (r_cnt[n] != '1)) begin
          r_cnt[n] <= r_cnt[n] + 32'd1;
        end
      end
    end
  end

endmodule
